// File: rtl/drain_pkg.sv
// Shared types and sizing for the FIFO drain controller and its output buffer.
package drain_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned OCC_W     = 2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order data buffer; entry 0 is always the head.
module skid_buf2
    import drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] head,
    output logic [OCC_W-1:0]      occ
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

    // Shift-down storage: a pop moves entry 1 into the head slot.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem[0] <= '0;
            mem[1] <= '0;
            occ    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    mem[occ[0]] <= dataIn;
                    occ         <= occ + OCC_W'(1);
                end
                2'b01: begin
                    mem[0] <= mem[1];
                    occ    <= occ - OCC_W'(1);
                end
                2'b11: begin
                    if (occ == OCC_W'(1)) begin
                        mem[0] <= dataIn;
                    end else begin
                        mem[0] <= mem[1];
                        mem[1] <= dataIn;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains an upstream FIFO in bursts onto a valid/ready port through a 2-entry buffer.
// Optional DRAIN_STATS_EN adds beatCnt/burstCnt statistics outputs.
module fifo_drain_ctrl
    import drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 4,
    parameter int unsigned TO_W       = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENB,
    input  logic                  fifoEmpty,
    input  logic                  fifoAlmostEmpty,
    input  logic [DATA_WIDTH-1:0] fifoData,
    output logic                  sRead,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outValid,
    input  logic                  inReady,
    output logic                  busy,
    output logic                  errUnderrun
`ifdef DRAIN_STATS_EN
    ,
    output logic [15:0]           beatCnt,
    output logic [7:0]            burstCnt
`endif
);

    state_t            state;
    state_t            stateNext;
    logic [TO_W-1:0]   toCnt;
    logic [TO_W-1:0]   toCntNext;
    logic              rdPend;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  credit;
    logic              room;
    logic              pop;
    logic              push;

    // Buffer traffic freezes with ENB so nothing moves while disabled.
    assign pop      = ENB & outValid & inReady;
    assign push     = ENB & rdPend;
    assign outValid = (occ != '0);
    assign credit   = occ + OCC_W'(rdPend) - OCC_W'(pop);
    assign room     = (credit < OCC_W'(BUF_DEPTH));

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .CLK    (CLK),
        .RST    (RST),
        .push   (push),
        .pop    (pop),
        .dataIn (fifoData),
        .head   (outData),
        .occ    (occ)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            toCnt       <= '0;
            rdPend      <= 1'b0;
            errUnderrun <= 1'b0;
        end else if (ENB) begin
            state  <= stateNext;
            toCnt  <= toCntNext;
            rdPend <= sRead;
            if (sRead && fifoEmpty) begin
                errUnderrun <= 1'b1;
            end
        end
    end

    // A small almost-empty residue still drains once the timeout expires.
    always_comb begin
        stateNext = state;
        toCntNext = toCnt;
        case (state)
            IDLE: begin
                if (fifoEmpty) begin
                    toCntNext = '0;
                end else if (!fifoAlmostEmpty) begin
                    stateNext = BURST;
                    toCntNext = '0;
                end else if (toCnt == TO_W'(TIMEOUT - 1)) begin
                    stateNext = BURST;
                    toCntNext = '0;
                end else begin
                    toCntNext = toCnt + TO_W'(1);
                end
            end
            BURST: begin
                if (fifoEmpty && !sRead) begin
                    stateNext = IDLE;
                    toCntNext = '0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == BURST);
        sRead = ENB & (state == BURST) & ~fifoEmpty & room;
    end

`ifdef DRAIN_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            beatCnt  <= '0;
            burstCnt <= '0;
        end else begin
            if (pop) begin
                beatCnt <= beatCnt + 16'(1);
            end
            if (ENB && (state == IDLE) && (stateNext == BURST)) begin
                burstCnt <= burstCnt + 8'(1);
            end
        end
    end
`endif

endmodule
